// File: rtl/multdiv_unit.sv
// Iterative signed/unsigned multiply-divide unit: shift-add multiply, restoring divide.
// Define MULTDIV_DIVZERO_EN to short-circuit division by zero with a div_zero flag.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    stateT state, nextState;

    logic [1:0]       opReg;
    logic [WIDTH-1:0] aReg, bReg, bMag, accHi, accLo;
    logic [CW-1:0]    count;

    logic             signedOp, isDiv, aNeg, bNeg, divByZero;
    logic [WIDTH-1:0] aMag, bMagNext;
    logic [WIDTH:0]   mulSum, divShift;
    logic             divFits;
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] fixHi, fixLo;

`ifdef MULTDIV_DIVZERO_EN
    logic dzReg;
    logic startDz;
    assign startDz = op[1] && (b == '0);
`endif

    assign signedOp  = ~opReg[0];
    assign isDiv     = opReg[1];
    assign aNeg      = signedOp & aReg[WIDTH-1];
    assign bNeg      = signedOp & bReg[WIDTH-1];
    assign divByZero = (bReg == '0);
    assign aMag      = aNeg ? -aReg : aReg;
    assign bMagNext  = bNeg ? -bReg : bReg;

    assign mulSum   = {1'b0, accHi} + ({1'b0, bMag} & {(WIDTH+1){accLo[0]}});
    assign divShift = {accHi, accLo[WIDTH-1]};
    assign divFits  = divShift >= {1'b0, bMag};
    assign divRem   = divShift[WIDTH-1:0] - bMag;

    // Quotient keeps its natural all-ones value when the divisor is zero.
    always_comb begin
        fixHi = accHi;
        fixLo = accLo;
        unique case (1'b1)
            !isDiv: begin
                if (aNeg ^ bNeg) {fixHi, fixLo} = -{accHi, accLo};
            end
            isDiv: begin
                if ((aNeg ^ bNeg) && !divByZero) fixLo = -accLo;
                if (aNeg) fixHi = -accHi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (start) begin
`ifdef MULTDIV_DIVZERO_EN
                    nextState = startDz ? DONE : CALC;
`else
                    nextState = CALC;
`endif
                end
            end
            CALC: if (count == LAST) nextState = FIX;
            FIX:  nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
`ifdef MULTDIV_DIVZERO_EN
        div_zero = (state == DONE) && dzReg;
`else
        div_zero = 1'b0;
`endif
    end

    // The first CALC cycle loads magnitudes; the remaining WIDTH do one bit each.
    always_ff @(posedge clock) begin
        if (reset) begin
            opReg <= '0;
            aReg  <= '0;
            bReg  <= '0;
            bMag  <= '0;
            accHi <= '0;
            accLo <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
`ifdef MULTDIV_DIVZERO_EN
            dzReg <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opReg <= op;
                        aReg  <= a;
                        bReg  <= b;
                        count <= '0;
`ifdef MULTDIV_DIVZERO_EN
                        dzReg <= startDz;
`endif
                    end
                end
                CALC: begin
                    count <= count + CW'(1);
                    if (count == '0) begin
                        accHi <= '0;
                        accLo <= aMag;
                        bMag  <= bMagNext;
                    end else if (isDiv) begin
                        accHi <= divFits ? divRem : divShift[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], divFits};
                    end else begin
                        {accHi, accLo} <= {mulSum, accLo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi <= fixHi;
                    lo <= fixLo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: reference model results queued at issue,
// popped and compared on each done pulse.
module tb_multdiv_unit;
    logic        clock = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic [7:0]  lat;
    } expT;

    expT         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prevHi = '0;
    logic [31:0] prevLo = '0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] h,
                                  output logic [31:0] l, output logic z);
        logic signed [63:0] sx, sy, p, q, r;
        logic [63:0]        u;
        sx = $signed({{32{x[31]}}, x});
        sy = $signed({{32{y[31]}}, y});
        z  = 1'b0;
        h  = '0;
        l  = '0;
        if (o[1] && y == '0) begin
`ifdef MULTDIV_DIVZERO_EN
            h = prevHi;
            l = prevLo;
            z = 1'b1;
`else
            h = x;
            l = '1;
`endif
        end else begin
            case (o)
                2'b00: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
                2'b01: begin
                    u = {32'b0, x} * {32'b0, y};
                    h = u[63:32];
                    l = u[31:0];
                end
                2'b10: begin
                    q = sx / sy;
                    r = sx % sy;
                    h = r[31:0];
                    l = q[31:0];
                end
                default: begin h = x % y; l = x / y; end
            endcase
        end
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        expT         e;
        logic [31:0] h, l;
        logic        z, stable, busyOk, seen;
        int          n;
        @(negedge clock);
        model(o, x, y, h, l, z);
        e.hi  = h;
        e.lo  = l;
        e.dz  = z;
        e.lat = z ? 8'd1 : 8'd34;
        sb.push_back(e);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        stable = 1'b1; busyOk = 1'b1; seen = 1'b0; n = 0;
        while (!seen && n < 100) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (!busy) busyOk = 1'b0;
            if (done) seen = 1'b1;
            else if (hi !== prevHi || lo !== prevLo) stable = 1'b0;
        end
        e = sb.pop_front();
        checkEq("timeout", 64'(seen), 64'(1));
        checkEq("latency", 64'(n), 64'(e.lat));
        checkEq("busy", 64'(busyOk), 64'(1));
        checkEq("hold", 64'(stable), 64'(1));
        checkEq("hi", 64'(hi), 64'(e.hi));
        checkEq("lo", 64'(lo), 64'(e.lo));
        checkEq("divzero", 64'(div_zero), 64'(e.dz));
        prevHi = e.hi;
        prevLo = e.lo;
    endtask

    initial begin
        int          dones;
        logic [31:0] capHi, capLo;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkEq("rst_hi", 64'(hi), 64'(0));
        checkEq("rst_lo", 64'(lo), 64'(0));
        checkEq("rst_busy", 64'(busy), 64'(0));
        checkEq("rst_done", 64'(done), 64'(0));
        checkEq("rst_dz", 64'(div_zero), 64'(0));
        reset = 1'b0;

        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'd100, 32'd0);
        issue(2'b10, 32'hFFFF_FF9C, 32'd0);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        issue(2'b11, 32'hFFFF_FFFF, 32'd1);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        issue(2'b00, 32'd0, 32'h1234_5678);
        for (int i = 0; i < 16; i++)
            issue(2'($urandom), $urandom, (i % 4 == 0) ? 32'($urandom_range(1, 9))
                                                       : $urandom);

        // Start held high with op/operands changing mid-operation.
        @(negedge clock);
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        @(posedge clock);
        dones = 0; capHi = '0; capLo = '0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (k == 5) begin op = 2'b10; a = 32'hDEAD_BEEF; b = 32'd0; end
            if (done) begin
                dones++;
                capHi = hi;
                capLo = lo;
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkEq("held_dones", 64'(dones), 64'(1));
        checkEq("held_hi", 64'(capHi), 64'(0));
        checkEq("held_lo", 64'(capLo), 64'(30));
        prevHi = 32'd0;
        prevLo = 32'd30;

        // Reset in CALC cycle 10, with start raised at the same time.
        @(negedge clock);
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkEq("abort_busy", 64'(busy), 64'(0));
        checkEq("abort_hi", 64'(hi), 64'(0));
        checkEq("abort_lo", 64'(lo), 64'(0));
        reset = 1'b0; start = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) dones++;
        end
        checkEq("abort_dones", 64'(dones), 64'(0));
        prevHi = '0;
        prevLo = '0;

        issue(2'b01, 32'd12345, 32'd678);
        issue(2'b11, 32'd1000, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
